// File: rtl/adder_result_seg7.sv
// Captures a 4-bit adder result on a valid strobe and holds it as one hex digit
// on a 7-segment display; overflowed results blink and light the decimal point.
module adder_result_seg7 #(
    parameter int HOLD_CYCLES = 1000,
    parameter int BLINK_HALF  = 100,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [2:0] sum_in,
    input  logic       cout_in,
    input  logic       valid_in,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [3:0] result_q,
    output logic       overflow_flag,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, SHOW, BLINK} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] hold_cnt, hold_next;
    logic [CNT_W-1:0] blink_cnt, blink_next;
    logic             visible, visible_next;
    logic [6:0]       seg_next;
    logic             dp_next;
    logic [3:0]       result_next;
    logic             overflow_next;
    logic             busy_next;
    logic [7:0]       drop_next;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            blink_cnt     <= '0;
            visible       <= 1'b0;
            seg_out       <= 7'h00;
            dp_out        <= 1'b0;
            result_q      <= 4'h0;
            overflow_flag <= 1'b0;
            busy          <= 1'b0;
            drop_cnt      <= 8'h00;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_next;
            blink_cnt     <= blink_next;
            visible       <= visible_next;
            seg_out       <= seg_next;
            dp_out        <= dp_next;
            result_q      <= result_next;
            overflow_flag <= overflow_next;
            busy          <= busy_next;
            drop_cnt      <= drop_next;
        end
    end

    // Everything holds its value unless ena is high, so freezing falls out of the defaults.
    always_comb begin
        state_next    = state;
        hold_next     = hold_cnt;
        blink_next    = blink_cnt;
        visible_next  = visible;
        seg_next      = seg_out;
        dp_next       = dp_out;
        result_next   = result_q;
        overflow_next = overflow_flag;
        busy_next     = busy;
        drop_next     = drop_cnt;

        if (ena) begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        result_next   = {cout_in, sum_in};
                        overflow_next = cout_in;
                        dp_next       = cout_in;
                        seg_next      = hex7({cout_in, sum_in});
                        busy_next     = 1'b1;
                        hold_next     = '0;
                        blink_next    = '0;
                        visible_next  = 1'b1;
                        state_next    = cout_in ? BLINK : SHOW;
                    end
                end
                SHOW, BLINK: begin
                    // A strobe on the final busy cycle still counts as dropped.
                    if (valid_in && drop_cnt != 8'hFF)
                        drop_next = drop_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        seg_next   = hex7(result_q);
                    end else begin
                        hold_next = hold_cnt + CNT_W'(1);
                        if (state == BLINK) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_next   = '0;
                                visible_next = ~visible;
                            end else begin
                                blink_next = blink_cnt + CNT_W'(1);
                            end
                            seg_next = visible_next ? hex7(result_q) : 7'h00;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_seg7.sv
// Directed bench for adder_result_seg7: a timing-level model is compared every
// cycle, and literal expectations from the worked examples pin that model.
module tb_adder_result_seg7;

    localparam int HOLD  = 8;
    localparam int BHALF = 2;

    logic       clk = 1'b0;
    logic       reset, ena, cout_in, valid_in;
    logic [2:0] sum_in;
    logic [6:0] seg_out;
    logic       dp_out, overflow_flag, busy;
    logic [3:0] result_q;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    bit compare_on = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [6:0] m_seg;
    logic       m_dp, m_ovf, m_busy;
    logic [3:0] m_result;
    logic [7:0] m_drop;
    int         m_age;

    adder_result_seg7 #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BHALF), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .ena(ena), .sum_in(sum_in), .cout_in(cout_in),
        .valid_in(valid_in), .seg_out(seg_out), .dp_out(dp_out), .result_q(result_q),
        .overflow_flag(overflow_flag), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Model: m_age is cycles elapsed since capture; visibility is simply age/BLINK_HALF parity.
    always @(posedge clk) begin
        if (reset) begin
            m_seg <= 7'h00; m_dp <= 1'b0; m_ovf <= 1'b0; m_busy <= 1'b0;
            m_result <= 4'h0; m_drop <= 8'h00; m_age <= 0;
        end else if (ena) begin
            if (m_busy) begin
                if (valid_in) m_drop <= (m_drop == 8'd255) ? 8'd255 : m_drop + 8'd1;
                if (m_age == HOLD - 1) begin
                    m_busy <= 1'b0;
                    m_seg  <= hex_tab[m_result];
                end else begin
                    m_age <= m_age + 1;
                    m_seg <= (!m_ovf || (((m_age + 1) / BHALF) % 2 == 0)) ? hex_tab[m_result] : 7'h00;
                end
            end else if (valid_in) begin
                m_result <= {cout_in, sum_in};
                m_ovf    <= cout_in;
                m_dp     <= cout_in;
                m_seg    <= hex_tab[{cout_in, sum_in}];
                m_busy   <= 1'b1;
                m_age    <= 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on)
            check_output("cycle_model",
                         {seg_out, dp_out, result_q, overflow_flag, busy, drop_cnt},
                         {m_seg, m_dp, m_result, m_ovf, m_busy, m_drop});
    end

    task automatic apply_stimulus(input logic r, input logic e, input logic v,
                                  input logic [2:0] s, input logic c);
        reset = r; ena = e; valid_in = v; sum_in = s; cout_in = c;
        @(negedge clk);
    endtask

    int busy_count;
    logic [6:0] seq [8];
    logic [6:0] blink_exp [8];

    initial begin
        blink_exp = '{7'h7C, 7'h7C, 7'h00, 7'h00, 7'h7C, 7'h7C, 7'h00, 7'h00};
        reset = 1'b1; ena = 1'b1; valid_in = 1'b0; sum_in = 3'd0; cout_in = 1'b0;
        @(negedge clk);
        apply_stimulus(1, 1, 0, 0, 0);
        compare_on = 1'b1;

        // Reset then idle
        for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0, 0);
        check_output("idle_seg", seg_out, 7'h00);
        check_output("idle_dp", dp_out, 0);
        check_output("idle_busy", busy, 0);
        check_output("idle_drop", drop_cnt, 0);

        // Plain capture of 5
        apply_stimulus(0, 1, 1, 3'd5, 0);
        check_output("cap5_result", result_q, 4'h5);
        check_output("cap5_seg", seg_out, 7'h6D);
        busy_count = busy ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            if (busy) busy_count++;
        end
        check_output("cap5_busy_len", busy_count, HOLD);
        check_output("cap5_seg_held", seg_out, 7'h6D);

        // Overflowed capture 3+carry -> B, blinking
        apply_stimulus(0, 1, 1, 3'd3, 1);
        check_output("capB_result", result_q, 4'hB);
        check_output("capB_dp", dp_out, 1);
        seq[0] = seg_out;
        for (int i = 1; i < 8; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            seq[i] = seg_out;
        end
        for (int i = 0; i < 8; i++) check_output($sformatf("blink_seg%0d", i), seq[i], blink_exp[i]);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("capB_after_seg", seg_out, 7'h7C);
        check_output("capB_after_dp", dp_out, 1);
        check_output("capB_after_busy", busy, 0);

        // Drops 3 cycles in and on the last busy cycle
        apply_stimulus(0, 1, 1, 3'd2, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 1, 3'd7, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 1, 1, 3'd6, 0);
        check_output("drop_busy_end", busy, 0);
        apply_stimulus(0, 1, 0, 0, 0);
        check_output("drop_cnt2", drop_cnt, 2);
        check_output("drop_seg", seg_out, 7'h5B);
        check_output("drop_result", result_q, 4'h2);

        // ena low for 5 cycles mid-BLINK with strobes
        apply_stimulus(0, 1, 1, 3'd7, 1);
        busy_count = 1;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            if (busy) busy_count++;
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, i % 2 == 0, 3'd1, 0);
            if (busy) busy_count++;
        end
        check_output("freeze_seg", seg_out, 7'h00);
        check_output("freeze_drop", drop_cnt, 2);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            if (busy) busy_count++;
        end
        check_output("freeze_busy_len", busy_count, HOLD + 5);
        check_output("freeze_seg_end", seg_out, 7'h71);

        // Saturating drop counter
        for (int i = 0; i < 300; i++) apply_stimulus(0, 1, 1, 3'd1, 0);
        check_output("drop_sat", drop_cnt, 255);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 0, 0);

        // Reset mid-SHOW, then capture
        apply_stimulus(0, 1, 1, 3'd4, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(1, 1, 1, 3'd5, 1);
        check_output("rst_seg", seg_out, 7'h00);
        check_output("rst_busy", busy, 0);
        check_output("rst_drop", drop_cnt, 0);
        check_output("rst_result", result_q, 0);
        apply_stimulus(0, 1, 1, 3'd6, 0);
        check_output("post_rst_seg", seg_out, 7'h7D);
        check_output("post_rst_busy", busy, 1);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 0, 0);

        compare_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
